program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Boot-time instruction store feeding the cpu's instr input. Receives a program as a byte
//  stream, packs bytes little-endian into 32-bit words and writes them into a 128-word
//  instruction RAM. Holds the cpu in reset until the load completes, then serves
//  instr = imem[pc] with one-cycle read latency, which the fetch/fetch_wait stages consume.
// PARAMETERS
//  ADDR_W   7        instruction address width; matches the cpu pc width
//  DEPTH    1<<ADDR_W  RAM depth in 32-bit words (128)
// PORTS
//  clk          in   1   system clock; all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  rx_data      in   8   program byte
//  rx_valid     in   1   rx_data valid
//  rx_ready     out  1   loader accepts byte; transfer = rx_valid & rx_ready
//  pc           in   7   cpu fetch address
//  instr        out  32  registered imem[pc]; 0 while not RUN
//  cpu_rst_n    out  1   drives cpu rst_n; low until RUN
//  load_done    out  1   high in RUN
//  load_err     out  1   high in ERROR
//  words_loaded out  8   words written so far (0..128)
// BEHAVIOUR
//  Reset: state=HDR, all outputs 0 (rx_ready 0 in reset, then 1 in HDR); counters 0; RAM unchanged.
//  States: HDR -> LOAD -> [CHK] -> RUN | ERROR. RUN and ERROR are terminal until rst_n.
//  rx_ready = 1 in HDR, LOAD, CHK; 0 in RUN/ERROR. Comb from state only, never from rx_valid.
//  HDR: accepted byte = N, the word count. N==0 or N>DEPTH -> ERROR; else latch N, go LOAD.
//  LOAD: byte_idx 0..3 counts bytes; byte k goes to word[8k+7:8k]. On the edge accepting
//   byte_idx==3, write the assembled word to imem[word_cnt], increment word_cnt/words_loaded,
//   clear byte_idx. If the new word_cnt==N -> CHK (CHECKSUM_EN) or RUN.
//  Stalls: rx_valid low for any number of cycles holds all state; no timeout.
//  RUN: cpu_rst_n, load_done are registered; both rise on the first RUN cycle.
//   The cpu sees its reset release one cycle after the last write.
//  instr: registered; instr(t+1) = imem[pc(t)] in RUN, else 0. Read of the address being written
//   is impossible (no write in RUN).
//  Word count width: word_cnt is 8 bits so N=128 does not wrap. The write address is word_cnt[6:0].
//  Async reset mid-load: returns to HDR, cpu_rst_n low, partial RAM contents kept but unused
//   until a full reload.
//  ERROR: cpu_rst_n stays 0, load_err=1, instr=0.
// CONFIGURATION
//  PROGRAM_LOADER_CHECKSUM_EN defined: the loader keeps a running XOR of every written word.
//   After N words, CHK accepts 4 more bytes (LE word C). C==xor -> RUN, else ERROR.
//   The transition happens on the edge accepting the 4th byte.
//  Not defined: no CHK state, no xor register; the loader goes LOAD->RUN directly.
//   load_err is raised only by bad N.
// STRUCTURE
//  Package program_loader_pkg: state enum {HDR,LOAD,CHK,RUN,ERROR}, ADDR_W/DEPTH
//   localparams, NOP_INSTR=32'h0.
//  Sub-module instr_ram: DEPTH x 32, one sync write port (we, waddr, wdata) and one sync
//   read port (raddr, rdata, 1-cycle). The 0-forcing of instr is done in program_loader.
// TESTING
//  1 N=3, bytes of 0xE3A01005,0xE2811001,0xEAFFFFFE (LE) -> words_loaded=3, cpu_rst_n rises
//    1 cycle after last byte; pc=1 -> instr=0xE2811001 next cycle.
//  2 N=0 -> load_err=1 next cycle, rx_ready=0, cpu_rst_n=0; N=200 -> same.
//  3 N=128, random rx_valid gaps -> all 128 words read back correctly; words_loaded=128, no wrap.
//  4 rst_n pulsed after 5 bytes of N=2 -> state HDR, words_loaded=0; fresh N=1 load -> RUN.
//  5 CHECKSUM_EN, N=2 words 0x1,0x3, C=0x2 -> RUN; C=0x5 -> ERROR, load_err=1, cpu_rst_n=0.
//  6 RUN: rx_valid=1 held -> rx_ready stays 0, RAM unchanged; instr=0 on every cycle before RUN.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Build option: PROGRAM_LOADER_CHECKSUM_EN adds the trailing checksum word check.
package program_loader_pkg;

    localparam int          ADDR_W    = 7;
    localparam int          DEPTH     = 1 << ADDR_W;
    localparam logic [7:0]  MAX_WORDS = 8'(DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHK   = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/program_loader_instr_ram.sv
// DEPTH x 32 instruction RAM: one synchronous write port, one synchronous read port.
// Contents are deliberately not reset so a reset mid-load keeps whatever was written.
module instr_ram
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/program_loader.sv
// Receives a byte-stream program (count byte, then LE words), fills the instruction RAM,
// holds the cpu in reset until done. PROGRAM_LOADER_CHECKSUM_EN enables the XOR check word.
module program_loader
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [7:0]        words_loaded,
    output state_t            dbg_state
);

    // Handshake: a byte transfers on a rising edge where rx_valid & rx_ready are both high.
    // rx_ready is a registered function of the state only; it never looks at rx_valid.
    state_t      state_q;
    logic        ready_q;
    logic [7:0]  n_q;
    logic [7:0]  word_cnt_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] asm_q;
    logic        cpu_rst_n_q;
    logic        load_done_q;
    logic        load_err_q;
    logic        instr_en_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] xor_q;
`endif

    logic        accept;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  word_cnt_d;

    assign accept     = rx_valid & ready_q;
    assign ram_wdata  = {rx_data, asm_q};
    assign ram_we     = (state_q == ST_LOAD) && accept && (byte_idx_q == 2'd3);
    assign word_cnt_d = word_cnt_q + 8'd1;

    instr_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_cnt_q[ADDR_W-1:0]),
        .wdata (ram_wdata),
        .raddr (pc),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HDR;
            ready_q     <= 1'b0;
            n_q         <= 8'd0;
            word_cnt_q  <= 8'd0;
            byte_idx_q  <= 2'd0;
            asm_q       <= 24'd0;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            instr_en_q  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q       <= 32'd0;
`endif
        end else begin
            // RAM data for pc is only exposed one cycle after a RUN cycle.
            instr_en_q <= (state_q == ST_RUN);
            case (state_q)
                ST_HDR: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (rx_data == 8'd0 || rx_data > MAX_WORDS) begin
                            state_q    <= ST_ERROR;
                            ready_q    <= 1'b0;
                            load_err_q <= 1'b1;
                        end else begin
                            n_q     <= rx_data;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (byte_idx_q == 2'd3) begin
                            byte_idx_q <= 2'd0;
                            word_cnt_q <= word_cnt_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            xor_q <= xor_q ^ ram_wdata;
                            if (word_cnt_d == n_q) begin
                                state_q <= ST_CHK;
                            end
`else
                            if (word_cnt_d == n_q) begin
                                state_q     <= ST_RUN;
                                ready_q     <= 1'b0;
                                cpu_rst_n_q <= 1'b1;
                                load_done_q <= 1'b1;
                            end
`endif
                        end else begin
                            asm_q[{byte_idx_q, 3'b000} +: 8] <= rx_data;
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        if (byte_idx_q == 2'd3) begin
                            byte_idx_q <= 2'd0;
                            ready_q    <= 1'b0;
                            if ({rx_data, asm_q} == xor_q) begin
                                state_q     <= ST_RUN;
                                cpu_rst_n_q <= 1'b1;
                                load_done_q <= 1'b1;
                            end else begin
                                state_q    <= ST_ERROR;
                                load_err_q <= 1'b1;
                            end
                        end else begin
                            asm_q[{byte_idx_q, 3'b000} +: 8] <= rx_data;
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
`endif
                ST_RUN: begin
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_ERROR;
                    ready_q    <= 1'b0;
                    load_err_q <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready     = ready_q;
    assign instr        = instr_en_q ? ram_rdata : NOP_INSTR;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = word_cnt_q;
    assign dbg_state    = state_q;

endmodule
